// File: rtl/pam4_pkg.sv
// pam4_pkg: shared PAM4 symbol type, BER FSM states and slicer function
package pam4_pkg;
  typedef logic [1:0] pam4_sym_t;
  typedef enum logic [1:0] {IDLE, ALIGN, COUNT, DONE} ber_state_t;
  function automatic pam4_sym_t pam4_slice(input int sample, input int sep);
    return sample < -sep ? 2'd0 : sample < 0 ? 2'd1 : sample < sep ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/pam4_slicer_ber_if.sv
// pam4_slicer_ber_if: control, sample/reference streams and BER results
interface pam4_slicer_ber_if import pam4_pkg::*; #(parameter int SIGNAL_RESOLUTION = 16, parameter int COUNT_WIDTH = 32);
  logic en;
  logic clear;
  pam4_sym_t ref_sym_in;
  logic ref_sym_valid;
  logic signed [SIGNAL_RESOLUTION-1:0] rx_in;
  logic rx_valid;
  pam4_sym_t sym_out;
  logic sym_out_valid;
  logic sym_error;
  logic [COUNT_WIDTH-1:0] err_count;
  logic [COUNT_WIDTH-1:0] sym_count;
  logic ber_done;
  logic fifo_overflow;
  logic fifo_underflow;
  modport master(output en, clear, ref_sym_in, ref_sym_valid, rx_in, rx_valid,
                 input sym_out, sym_out_valid, sym_error, err_count, sym_count, ber_done, fifo_overflow, fifo_underflow);
  modport slave(input en, clear, ref_sym_in, ref_sym_valid, rx_in, rx_valid,
                output sym_out, sym_out_valid, sym_error, err_count, sym_count, ber_done, fifo_overflow, fifo_underflow);
endinterface

// File: rtl/ref_sym_fifo.sv
// ref_sym_fifo: single-clock FIFO; a push while full is accepted only alongside a pop
module ref_sym_fifo #(parameter int W = 2, parameter int DEPTH = 16) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr_en, rd_en;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    dout = mem_q[rd_q];
    wr_en = push && (!full || pop) && !clear;
    rd_en = pop && !empty && !clear;
    wr_d = clear ? '0 : wr_q + AW'(wr_en);
    rd_d = clear ? '0 : rd_q + AW'(rd_en);
    cnt_d = clear ? '0 : cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= din;
endmodule

// File: rtl/pam4_slicer_ber.sv
// pam4_slicer_ber: PAM4 slicer with reference alignment and saturating BER counters
module pam4_slicer_ber import pam4_pkg::*; #(
  parameter int SIGNAL_RESOLUTION = 16,
  parameter int SYMBOL_SEPERATION = 64,
  parameter int CURSOR_DELAY = 3,
  parameter int REF_FIFO_DEPTH = 16,
  parameter int TEST_LENGTH = 1000,
  parameter int COUNT_WIDTH = 32
) (
  input logic clk,
  input logic rstn,
  pam4_slicer_ber_if.slave bus
);
  localparam int CW = COUNT_WIDTH;
  localparam int SW = $clog2(CURSOR_DELAY + 2);
  localparam logic [SW-1:0] SKIP_END = SW'(CURSOR_DELAY);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] TLEN = CW'(TEST_LENGTH);
  ber_state_t state_q, state_d;
  logic [SW-1:0] skip_q, skip_d;
  pam4_sym_t sym_out_q, sym_out_d, slice, head;
  logic vld_q, vld_d, err_q, err_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [CW-1:0] err_count_q, err_count_d, sym_count_q, sym_count_d;
  logic act, rx, push, cmp, full, empty;
  ref_sym_fifo #(.W(2), .DEPTH(REF_FIFO_DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .clear(bus.clear), .push(push), .pop(cmp),
    .din(bus.ref_sym_in), .dout(head), .full(full), .empty(empty)
  );
  always_comb begin
    slice = pam4_slice(int'($signed(bus.rx_in[SIGNAL_RESOLUTION-1:0])), SYMBOL_SEPERATION);
    act = bus.en && !bus.clear;
    rx = act && bus.rx_valid && state_q != IDLE;
    push = act && bus.ref_sym_valid && state_q != DONE;
    cmp = rx && state_q == COUNT && !empty;
    state_d = state_q;
    skip_d = skip_q;
    sym_out_d = rx ? slice : sym_out_q;
    vld_d = rx;
    err_d = cmp && slice != head;
    err_count_d = err_count_q + CW'(err_d && err_count_q != CMAX);
    sym_count_d = sym_count_q + CW'(cmp && sym_count_q != CMAX);
    ovf_d = ovf_q || (push && full && !cmp);
    udf_d = udf_q || (rx && state_q == COUNT && empty);
    if (state_q == IDLE && push) state_d = ALIGN;
    if (state_q == ALIGN && rx) begin
      skip_d = skip_q + SW'(1);
      if (skip_d == SKIP_END) state_d = COUNT;
    end
    if (cmp && sym_count_d == TLEN) state_d = DONE;
    if (bus.clear) begin
      state_d = IDLE;
      skip_d = '0;
      sym_out_d = '0;
      err_count_d = '0;
      sym_count_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      skip_q <= '0;
      sym_out_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      err_count_q <= '0;
      sym_count_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q <= skip_d;
      sym_out_q <= sym_out_d;
      vld_q <= vld_d;
      err_q <= err_d;
      err_count_q <= err_count_d;
      sym_count_q <= sym_count_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  assign bus.sym_out = sym_out_q;
  assign bus.sym_out_valid = vld_q;
  assign bus.sym_error = err_q;
  assign bus.err_count = err_count_q;
  assign bus.sym_count = sym_count_q;
  assign bus.ber_done = state_q == DONE;
  assign bus.fifo_overflow = ovf_q;
  assign bus.fifo_underflow = udf_q;
endmodule

// File: tb/tb_pam4_slicer_ber.sv
// tb_pam4_slicer_ber: directed checks of slicing, alignment, FIFO flags, clear and reset
module tb_pam4_slicer_ber;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  pam4_slicer_ber_if bus ();
  pam4_slicer_ber dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
  function automatic logic signed [15:0] lvl(input int s);
    return 16'(s == 0 ? -96 : s == 1 ? -32 : s == 2 ? 32 : 96);
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input bit rv, input logic signed [15:0] rx, input bit fv, input logic [1:0] rs);
    bus.rx_valid = rv;
    bus.rx_in = rx;
    bus.ref_sym_valid = fv;
    bus.ref_sym_in = rs;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.ref_sym_valid = 1'b0;
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_sym_out"}, 64'(bus.sym_out), 0);
    chk({tag, "_valid"}, 64'(bus.sym_out_valid), 0);
    chk({tag, "_error"}, 64'(bus.sym_error), 0);
    chk({tag, "_err_count"}, 64'(bus.err_count), 0);
    chk({tag, "_sym_count"}, 64'(bus.sym_count), 0);
    chk({tag, "_done"}, 64'(bus.ber_done), 0);
    chk({tag, "_ovf"}, 64'(bus.fifo_overflow), 0);
    chk({tag, "_udf"}, 64'(bus.fifo_underflow), 0);
  endtask
  task automatic stream(input int n, input bit inj);
    for (int c = 0; c < n; c++) begin
      int m;
      bit forced;
      logic signed [15:0] rx;
      m = c - 4;
      forced = inj && c >= 4 && m % 100 == 99 && m < 1000;
      rx = c < 4 ? lvl(0) : lvl(m % 4);
      if (forced) rx = lvl(m % 4 == 3 ? 2 : m % 4 + 1);
      step(c >= 1, rx, 1'b1, 2'(c % 4));
      if (inj) chk("sym_error_pulse", 64'(bus.sym_error), 64'(forced));
    end
  endtask
  initial begin
    int bvals [6] = '{-65, -64, -1, 0, 63, 64};
    int bexp [6] = '{0, 1, 1, 2, 2, 3};
    bus.en = 1'b1;
    bus.clear = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_in = '0;
    bus.ref_sym_valid = 1'b0;
    bus.ref_sym_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rstn = 1'b1;
    stream(1004, 1'b0);
    chk("loop_sym_count", 64'(bus.sym_count), 1000);
    chk("loop_err_count", 64'(bus.err_count), 0);
    chk("loop_done", 64'(bus.ber_done), 1);
    chk("loop_ovf", 64'(bus.fifo_overflow), 0);
    chk("loop_udf", 64'(bus.fifo_underflow), 0);
    step(1'b1, lvl(3), 1'b1, 2'd0);
    chk("done_slice", 64'(bus.sym_out), 3);
    chk("done_valid", 64'(bus.sym_out_valid), 1);
    chk("done_frozen", 64'(bus.sym_count), 1000);
    step(1'b0, lvl(0), 1'b0, 2'd0);
    chk("hold_valid", 64'(bus.sym_out_valid), 0);
    chk("hold_sym_out", 64'(bus.sym_out), 3);
    do_clear();
    chk("clr_done", 64'(bus.ber_done), 0);
    chk("clr_sym_count", 64'(bus.sym_count), 0);
    step(1'b0, lvl(0), 1'b1, 2'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'(bvals[i]), 1'b0, 2'd0);
      chk($sformatf("thr_%0d", bvals[i]), 64'(bus.sym_out), 64'(bexp[i]));
      chk("thr_valid", 64'(bus.sym_out_valid), 1);
    end
    do_clear();
    stream(1004, 1'b1);
    chk("inj_err_count", 64'(bus.err_count), 10);
    chk("inj_sym_count", 64'(bus.sym_count), 1000);
    chk("inj_done", 64'(bus.ber_done), 1);
    do_clear();
    for (int k = 0; k < 17; k++) begin
      step(1'b0, lvl(0), 1'b1, 2'(k == 16 ? 3 : k % 4));
      if (k == 15) chk("ovf_not_yet", 64'(bus.fifo_overflow), 0);
    end
    chk("ovf_set", 64'(bus.fifo_overflow), 1);
    for (int k = 0; k < 19; k++) step(1'b1, k < 3 ? lvl(3) : lvl((k - 3) % 4), 1'b0, 2'd0);
    chk("ovf_sym_count", 64'(bus.sym_count), 16);
    chk("ovf_err_count", 64'(bus.err_count), 0);
    chk("ovf_no_udf", 64'(bus.fifo_underflow), 0);
    step(1'b1, lvl(0), 1'b0, 2'd0);
    chk("ovf_udf", 64'(bus.fifo_underflow), 1);
    chk("ovf_udf_count", 64'(bus.sym_count), 16);
    do_clear();
    step(1'b0, lvl(0), 1'b1, 2'd0);
    step(1'b0, lvl(0), 1'b1, 2'd1);
    for (int k = 0; k < 8; k++) step(1'b1, k == 3 ? lvl(0) : k == 4 ? lvl(1) : lvl(3), 1'b0, 2'd0);
    chk("udf_sym_count", 64'(bus.sym_count), 2);
    chk("udf_err_count", 64'(bus.err_count), 0);
    chk("udf_flag", 64'(bus.fifo_underflow), 1);
    chk("udf_not_done", 64'(bus.ber_done), 0);
    step(1'b0, lvl(0), 1'b1, 2'd2);
    step(1'b1, lvl(2), 1'b0, 2'd0);
    chk("udf_resume_count", 64'(bus.sym_count), 3);
    chk("udf_resume_err", 64'(bus.err_count), 0);
    do_clear();
    stream(504, 1'b0);
    chk("mid_sym_count", 64'(bus.sym_count), 500);
    do_clear();
    chk_zero("clear_mid");
    stream(1004, 1'b0);
    chk("rerun_sym_count", 64'(bus.sym_count), 1000);
    chk("rerun_err_count", 64'(bus.err_count), 0);
    chk("rerun_done", 64'(bus.ber_done), 1);
    do_clear();
    stream(504, 1'b0);
    chk("mid2_sym_count", 64'(bus.sym_count), 500);
    #2 rstn = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1 rstn = 1'b1;
    stream(1004, 1'b0);
    chk("rst_rerun_count", 64'(bus.sym_count), 1000);
    chk("rst_rerun_err", 64'(bus.err_count), 0);
    chk("rst_rerun_done", 64'(bus.ber_done), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pam4_slicer_ber.md
Name: pam4_slicer_ber

Overview:
- Receiver back-end stage directly downstream of the noise-injection stage.
- Takes the noisy received sample stream and slices each sample to a PAM4 symbol.
- Aligns the decisions against the transmitted reference symbol stream, buffered in an internal FIFO, and accumulates error and symbol counts for BER measurement.
- Finishes after a programmed number of compared symbols.

Parameters:
- SIGNAL_RESOLUTION, 16: width of signed received sample.
- SYMBOL_SEPERATION, 64: PAM4 level spacing in LSBs. Slicer thresholds are -S, 0, +S.
- CURSOR_DELAY, 3: received samples discarded before the first comparison (main-cursor latency of channel model).
- REF_FIFO_DEPTH, 16: reference FIFO entries; power of 2, ≥ CURSOR_DELAY+2.
- TEST_LENGTH, 1000: compared symbols before DONE.
- COUNT_WIDTH, 32: width of error/symbol counters.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- en  in  1  global enable; when low, all state holds and inputs are ignored
- clear  in  1  sync restart: counters, FIFO, flags to reset values, FSM to IDLE
- ref_sym_in  in  2  transmitted PAM4 symbol (0..3)
- ref_sym_valid  in  1  push ref_sym_in
- rx_in  in  SIGNAL_RESOLUTION  signed noisy received sample
- rx_valid  in  1  rx_in qualifier
- sym_out  out  2  sliced decision
- sym_out_valid  out  1  one-cycle pulse per sliced sample
- sym_error  out  1  pulse with sym_out_valid when compared decision ≠ reference
- err_count  out  COUNT_WIDTH  accumulated errors
- sym_count  out  COUNT_WIDTH  accumulated compared symbols
- ber_done  out  1  high in DONE
- fifo_overflow  out  1  sticky
- fifo_underflow  out  1  sticky

Behaviour:
- Reset (rstn low, async): all outputs 0, FIFO empty, FSM IDLE, skip counter 0.
- Slicer, with S=SYMBOL_SEPERATION and signed compare:
  - rx < -S → 0
  - -S ≤ rx < 0 → 1
  - 0 ≤ rx < S → 2
  - rx ≥ S → 3
- Output latency: sym_out/sym_out_valid are registered 1 cycle after an rx_valid cycle, in every state except IDLE. sym_error, err_count and sym_count update on that same registered edge.
- sym_out holds its last value when not valid. Pulses last one cycle.
- FIFO:
  - Push on ref_sym_valid&&en in any state except DONE.
  - Full with push and no pop in the same cycle: push dropped, fifo_overflow set.
  - Simultaneous push+pop when full is legal: count unchanged.
  - Read/write pointers wrap at REF_FIFO_DEPTH.
- FSM:
  - IDLE: exit to ALIGN on first ref_sym_valid&&en (that symbol is pushed).
  - ALIGN: each rx_valid increments skip counter. The sample is sliced and output, but is not compared and does not pop. When skip counter reaches CURSOR_DELAY, go to COUNT. The next rx_valid is the first compared sample.
  - COUNT: each rx_valid pops the FIFO head and compares it to the slice.
    - Mismatch → sym_error=1 and err_count+1.
    - sym_count+1 on every compare.
    - FIFO empty on rx_valid: no pop, no compare, no count change, fifo_underflow set.
    - When sym_count reaches TEST_LENGTH (on the edge it increments to TEST_LENGTH), go to DONE.
  - DONE: ber_done=1. Counters frozen, further rx/ref ignored except slicing output continues. Leave only via clear or reset.
- Counters saturate at 2^COUNT_WIDTH-1 and never wrap.
- clear takes priority over all same-cycle events. Reset mid-test discards everything; no partial results are retained.
- en low: no pushes, pops, slices or state change. Pulses deassert.

Decomposition:
- Shared package pam4_pkg:
  - pam4_sym_t (logic [1:0])
  - ber_state_t enum {IDLE, ALIGN, COUNT, DONE}
  - slicer function pam4_slice(sample, sep)
- One natural sub-module: ref_sym_fifo. Synchronous single-clock FIFO with width and depth parameters and full/empty/push/pop. It is reusable by the Tx-side checkers.

Test Plan:
- Clean loopback: refs 0,1,2,3 repeating; rx = ideal levels -96,-32,32,96 (S=64), delayed 3 samples → after 1000 compares sym_count=1000, err_count=0, ber_done=1.
- Threshold boundaries: rx = -65,-64,-1,0,63,64 → sym_out = 0,1,1,2,2,3, each one cycle after its rx_valid.
- Injected errors: same as loopback but every 100th rx is forced to the adjacent level → err_count=10 at done; sym_error pulses coincide with the forced samples.
- FIFO overflow: push 17 refs with no rx → fifo_overflow=1, FIFO holds the first 16. Then 3+16 rx samples compare against those 16 only.
- Underflow/alignment: send CURSOR_DELAY+5 rx with only 2 refs → sym_count=2, fifo_underflow=1, FSM still in COUNT.
- Reset/clear mid-COUNT: assert clear at sym_count=500 → all outputs 0, FSM IDLE. A rerun gives fresh counts; async rstn pulse mid-cycle gives the same result.
